// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for one iterative divider and one iterative multiplier.
// Accepts MULT/DIV/MTHI/MTLO in IDLE, launches the unit, commits results, flags Div0/timeout.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        div_start,
  input  logic        div_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        Div0,
  output logic        timeout
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH_DIV,
    LAUNCH_MULT,
    WAIT,
    DONE,
    EXC
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          unit_div;

  // Only the launched unit's done is honoured while waiting.
  logic unit_done_c;
  assign unit_done_c = unit_div ? div_done : mult_done;

  // Outputs are registered together with the state they decode from.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      unit_div   <= 1'b0;
      opA        <= '0;
      opB        <= '0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      Div0       <= 1'b0;
      timeout    <= 1'b0;
      div_start  <= 1'b0;
      mult_start <= 1'b0;
    end else begin
      div_start  <= 1'b0;
      mult_start <= 1'b0;
      done       <= 1'b0;
      Div0       <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opA  <= A;
            opB  <= B;
            busy <= 1'b1;
            case (op)
              OP_DIV: begin
                if (B == 32'd0) begin
                  state <= EXC;
                  Div0  <= 1'b1;
                  done  <= 1'b1;
                end else begin
                  state     <= LAUNCH_DIV;
                  unit_div  <= 1'b1;
                  div_start <= 1'b1;
                end
              end
              OP_MULT: begin
                state      <= LAUNCH_MULT;
                unit_div   <= 1'b0;
                mult_start <= 1'b1;
              end
              OP_MTHI: begin
                hi    <= A;
                state <= DONE;
                done  <= 1'b1;
              end
              OP_MTLO: begin
                lo    <= A;
                state <= DONE;
                done  <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        end
        LAUNCH_DIV, LAUNCH_MULT: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (unit_done_c) begin
            hi    <= unit_div ? div_hi : mult_hi;
            lo    <= unit_div ? div_lo : mult_lo;
            state <= DONE;
            done  <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE, EXC: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against a transaction-level HI/LO model.
// Unit latency L = WAIT cycles before the one in which the unit signals done.
module tb_muldiv_ctrl;

  localparam int TIMEOUT = 64;
  localparam int CW      = 7;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;
  localparam int NEVER = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        div_done = 1'b0, mult_done = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;
  logic        div_start, mult_start, busy, done, Div0, timeout;
  logic [31:0] opA, opB, hi, lo;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .div_start(div_start), .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
    .mult_start(mult_start), .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .opA(opA), .opB(opB), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .Div0(Div0), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction; samples are taken on each falling edge, sample n follows start edge + (n-1).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] rhi, input logic [31:0] rlo,
                        input bit spurious, input bit inject);
    int exp_at, n_max;
    bit exp_div0, exp_to, use_div, use_mult;
    logic [31:0] e_hi, e_lo;
    int ds_cnt, ds_at, ms_cnt, ms_at, dn_cnt, dn_at, d0_cnt, d0_at, to_cnt, to_at, busy_cnt;
    logic [31:0] got_opa, got_opb;
    e_hi = m_hi; e_lo = m_lo;
    exp_div0 = 0; exp_to = 0; use_div = 0; use_mult = 0;
    ds_cnt = 0; ds_at = 0; ms_cnt = 0; ms_at = 0; dn_cnt = 0; dn_at = 0;
    d0_cnt = 0; d0_at = 0; to_cnt = 0; to_at = 0; busy_cnt = 0;
    got_opa = '0; got_opb = '0;
    exp_at = 1;
    case (o)
      OP_MTHI: e_hi = a;
      OP_MTLO: e_lo = a;
      default: begin
        if (o == OP_DIV && b == 32'd0) exp_div0 = 1;
        else begin
          use_div  = (o == OP_DIV);
          use_mult = (o == OP_MULT);
          if (lat < TIMEOUT) begin
            e_hi = rhi; e_lo = rlo; exp_at = lat + 3;
          end else begin
            exp_to = 1; exp_at = TIMEOUT + 2;
          end
        end
      end
    endcase
    n_max = exp_at + 1;

    @(negedge clock);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clock);
    #1;
    start = 1'b0; A = $urandom; B = $urandom;
    for (int n = 1; n <= n_max; n++) begin
      @(negedge clock);
      if (n == 1) begin got_opa = opA; got_opb = opB; end
      if (div_start)  begin ds_cnt++; ds_at = n; end
      if (mult_start) begin ms_cnt++; ms_at = n; end
      if (done)       begin dn_cnt++; dn_at = n; end
      if (Div0)       begin d0_cnt++; d0_at = n; end
      if (timeout)    begin to_cnt++; to_at = n; end
      if (busy && n < n_max) busy_cnt++;
      if (n == n_max) check("busy_after", 64'(busy), 64'd0);
      // Unit models for the cycle that follows this sample.
      div_done  = (use_div  && n == lat + 2) || (spurious && use_mult && n >= 2 && n < exp_at);
      mult_done = (use_mult && n == lat + 2) || (spurious && use_div  && n >= 2 && n < exp_at);
      div_hi  = (use_div  && n == lat + 2) ? rhi : $urandom;
      div_lo  = (use_div  && n == lat + 2) ? rlo : $urandom;
      mult_hi = (use_mult && n == lat + 2) ? rhi : $urandom;
      mult_lo = (use_mult && n == lat + 2) ? rlo : $urandom;
      if (inject && n == 4 && exp_at > 6) begin
        start = 1'b1; op = OP_MTHI; A = 32'hAB;
      end else begin
        start = 1'b0;
      end
    end
    div_done = 1'b0; mult_done = 1'b0; start = 1'b0;

    check("opA", 64'(got_opa), 64'(a));
    check("opB", 64'(got_opb), 64'(b));
    check("done_count", 64'(dn_cnt), 64'd1);
    check("done_cycle", 64'(dn_at), 64'(exp_at));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_at));
    check("div_start_count", 64'(ds_cnt), 64'(use_div));
    check("mult_start_count", 64'(ms_cnt), 64'(use_mult));
    if (use_div)  check("div_start_cycle", 64'(ds_at), 64'd1);
    if (use_mult) check("mult_start_cycle", 64'(ms_at), 64'd1);
    check("div0_count", 64'(d0_cnt), 64'(exp_div0));
    if (exp_div0) check("div0_cycle", 64'(d0_at), 64'(exp_at));
    check("timeout_count", 64'(to_cnt), 64'(exp_to));
    if (exp_to) check("timeout_cycle", 64'(to_at), 64'(exp_at));
    check("hi", 64'(hi), 64'(e_hi));
    check("lo", 64'(lo), 64'(e_lo));
    m_hi = e_hi; m_lo = e_lo;
  endtask

  task automatic reset_mid_div();
    int dn_cnt;
    dn_cnt = 0;
    @(negedge clock);
    start = 1'b1; op = OP_DIV; A = 32'd50; B = 32'd5;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_opA", 64'(opA), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    div_done = 1'b1; div_hi = 32'd0; div_lo = 32'd10;
    @(negedge clock);
    div_done = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (done) dn_cnt++;
    end
    check("rst_late_done", 64'(dn_cnt), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b, rh, rl;
    logic [63:0] p;
    int lat;
    #1 reset = 1'b1;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_opB", 64'(opB), 64'd0);
    check("reset_pulses", 64'({done, Div0, timeout, div_start, mult_start}), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op(OP_DIV, 32'd100, 32'd7, 32, 32'd2, 32'd14, 0, 0);
    run_op(OP_MTHI, 32'h11, 32'd0, 0, 32'd0, 32'd0, 0, 0);
    run_op(OP_MTLO, 32'h22, 32'd0, 0, 32'd0, 32'd0, 0, 0);
    run_op(OP_DIV, 32'd5, 32'd0, 4, 32'd9, 32'd9, 0, 0);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 10, 32'd1, 32'hFFFF_FFFE, 1, 0);
    run_op(OP_DIV, 32'd1000, 32'd3, 20, 32'd1, 32'd333, 0, 1);
    run_op(OP_MTLO, 32'hCD, 32'd0, 0, 32'd0, 32'd0, 0, 0);
    run_op(OP_MULT, 32'd3, 32'd4, NEVER, 32'd0, 32'd12, 0, 0);
    run_op(OP_MULT, 32'd5, 32'd6, TIMEOUT - 1, 32'd0, 32'd30, 0, 0);
    run_op(OP_DIV, 32'd9, 32'd4, 0, 32'd1, 32'd2, 1, 0);
    reset_mid_div();
    run_op(OP_MULT, 32'd7, 32'd8, 5, 32'd0, 32'd56, 0, 0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(3, 0));
      a = $urandom;
      b = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
      lat = ($urandom_range(7, 0) == 0) ? TIMEOUT + 5 : int'($urandom_range(40, 0));
      if (o == OP_MULT) begin
        p = 64'(a) * 64'(b);
        rh = p[63:32]; rl = p[31:0];
      end else if (o == OP_DIV && b != 32'd0) begin
        rh = a % b; rl = a / b;
      end else begin
        rh = $urandom; rl = $urandom;
      end
      run_op(o, a, b, lat, rh, rl, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
